// File: rtl/beehive_noc_out_arbiter.sv
// Round-robin, wormhole-locked arbiter sharing one credit-based NoC output link among NUM_SRCS val/rdy sources.
// Latency is 1 cycle from accept to noc_val_out. src_rdy drops while the downstream NIB has no free slot.
module beehive_noc_out_arbiter #(
  parameter int NUM_SRCS    = 4,
  parameter int SRC_W       = 2,
  parameter int DATA_W      = 512,
  parameter int BUFFER_SIZE = 4,
  parameter int BUFFER_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRCS-1:0]        src_val,
  input  logic [NUM_SRCS*DATA_W-1:0] src_data,
  input  logic [NUM_SRCS-1:0]        src_last,
  output logic [NUM_SRCS-1:0]        src_rdy,
  output logic                       noc_val_out,
  output logic [DATA_W-1:0]          noc_data_out,
  input  logic                       noc_yummy_in,
  output logic [BUFFER_BITS-1:0]     credits_o,
  output logic                       busy_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state, state_next;
  logic [SRC_W-1:0]       rr_ptr, rr_next;
  logic [SRC_W-1:0]       owner, owner_next;
  logic [SRC_W-1:0]       cand, sel;
  logic                   cand_vld;
  logic                   yummy_f;
  logic [BUFFER_BITS-1:0] credits, credits_next;
  logic                   credit_ok;
  logic                   xfer;
  logic [DATA_W-1:0]      src_flit [NUM_SRCS];

  for (genvar g = 0; g < NUM_SRCS; g++) begin : g_flit
    assign src_flit[g] = src_data[g*DATA_W +: DATA_W];
  end

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] i);
    if (int'(i) == NUM_SRCS - 1) return '0;
    return i + 1'b1;
  endfunction

  // Scan downward so the source closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [SRC_W-1:0] idx;
    idx      = '0;
    cand     = '0;
    cand_vld = 1'b0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRCS);
      if (src_val[idx]) begin
        cand     = idx;
        cand_vld = 1'b1;
      end
    end
  end

  always_comb begin
    credit_ok  = (credits != '0);
    sel        = (state == LOCKED) ? owner : cand;
    src_rdy    = '0;
    if (!reset && credit_ok && (state == LOCKED || cand_vld))
      src_rdy[sel] = 1'b1;
    xfer       = |(src_val & src_rdy);
    state_next = state;
    rr_next    = rr_ptr;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (src_last[sel]) begin
            rr_next = next_src(sel);
          end else begin
            state_next = LOCKED;
            owner_next = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && src_last[sel]) begin
          state_next = IDLE;
          rr_next    = next_src(owner);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A returned credit and a spent credit in the same cycle cancel; a stray yummy at full count is dropped.
  always_comb begin
    credits_next = credits;
    if (yummy_f && !xfer && credits != BUFFER_BITS'(BUFFER_SIZE))
      credits_next = credits + 1'b1;
    else if (!yummy_f && xfer)
      credits_next = credits - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      owner  <= owner_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits      <= BUFFER_BITS'(BUFFER_SIZE);
      yummy_f      <= 1'b0;
      noc_val_out  <= 1'b0;
      noc_data_out <= '0;
    end else begin
      credits     <= credits_next;
      yummy_f     <= noc_yummy_in;
      noc_val_out <= xfer;
      if (xfer)
        noc_data_out <= src_flit[sel];
    end
  end

  assign credits_o = credits;
  assign busy_o    = (state == LOCKED);

endmodule

// File: tb/tb_beehive_noc_out_arbiter.sv
// Directed bench for beehive_noc_out_arbiter: queued val/rdy sources, a yummy-returning sink model, hand-computed expectations.
module tb_beehive_noc_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int BB = 3;
  localparam int QD = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_val, src_last, src_rdy;
  logic [N*DW-1:0] src_data;
  logic            noc_val_out;
  logic [DW-1:0]   noc_data_out;
  logic            noc_yummy_in;
  logic [BB-1:0]   credits_o;
  logic            busy_o;

  beehive_noc_out_arbiter #(
    .NUM_SRCS(N), .SRC_W(2), .DATA_W(DW), .BUFFER_SIZE(4), .BUFFER_BITS(BB)
  ) dut (
    .clk(clk), .reset(reset),
    .src_val(src_val), .src_data(src_data), .src_last(src_last), .src_rdy(src_rdy),
    .noc_val_out(noc_val_out), .noc_data_out(noc_data_out),
    .noc_yummy_in(noc_yummy_in), .credits_o(credits_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fl_dat  [N][QD];
  logic          fl_last [N][QD];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  hold;
  logic [N-1:0]  rdy_s;
  logic [DW-1:0] out_log [$];
  logic          last_val;
  int            owed;
  bit            auto_yum;
  int            min_cred;
  int            checks = 0;
  int            errors = 0;
  int            base;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int s, input int q);
    logic [DW-1:0] d;
    d            = '0;
    d[15:8]      = s[7:0];
    d[7:0]       = q[7:0];
    d[DW-1 -: 16] = {q[7:0], s[7:0]};
    return d;
  endfunction

  task automatic push_pkt(input int s, input int len, input int seq0);
    for (int k = 0; k < len; k++) begin
      fl_dat[s][tail[s]]  = mk(s, seq0 + k);
      fl_last[s][tail[s]] = (k == len - 1);
      tail[s]++;
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    hold     = '0;
    owed     = 0;
    auto_yum = 1'b0;
  endtask

  // One clock: drive inputs, sample rdy at negedge, pop accepted flits and log outputs after the edge.
  task automatic step();
    logic [N-1:0] fire;
    for (int i = 0; i < N; i++) begin
      if (head[i] != tail[i] && !hold[i]) begin
        src_val[i]             = 1'b1;
        src_last[i]            = fl_last[i][head[i]];
        src_data[i*DW +: DW]   = fl_dat[i][head[i]];
      end else begin
        src_val[i]             = 1'b0;
        src_last[i]            = 1'b0;
        src_data[i*DW +: DW]   = '0;
      end
    end
    noc_yummy_in = (owed > 0);
    if (owed > 0) owed--;
    @(negedge clk);
    rdy_s = src_rdy;
    fire  = src_val & src_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i]) head[i]++;
    last_val = noc_val_out;
    if (noc_val_out) begin
      out_log.push_back(noc_data_out);
      if (auto_yum) owed++;
    end
    if (int'(credits_o) < min_cred) min_cred = int'(credits_o);
  endtask

  task automatic do_reset(input int cycles);
    clear_srcs();
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) step();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    src_val      = '0;
    src_last     = '0;
    src_data     = '0;
    noc_yummy_in = 1'b0;
    min_cred     = 99;
    clear_srcs();

    // Reset state
    do_reset(2);
    check("rst_val",     noc_val_out,  1'b0);
    check("rst_data",    noc_data_out, '0);
    check("rst_credits", credits_o,    3'd4);
    check("rst_busy",    busy_o,       1'b0);
    check("rst_rdy",     src_rdy,      4'b0000);

    // 1: three-flit packet from src0, sink returns a yummy one cycle after each flit
    auto_yum = 1'b1;
    min_cred = 99;
    base     = out_log.size();
    push_pkt(0, 3, 0);
    step(); check("t1_val0", last_val, 1'b1); check("t1_busy", busy_o, 1'b1);
    step(); check("t1_val1", last_val, 1'b1);
    step(); check("t1_val2", last_val, 1'b1); check("t1_idle", busy_o, 1'b0);
    step(); check("t1_val3", last_val, 1'b0);
    step(); check("t1_cred_back", credits_o, 3'd4);
    check("t1_min_cred", min_cred, 2);
    for (int k = 0; k < 3; k++) check("t1_data", out_log[base + k], mk(0, k));

    // 2: credit exhaustion on a six-flit packet from src1
    auto_yum = 1'b0;
    base     = out_log.size();
    push_pkt(1, 6, 0);
    for (int c = 0; c < 6; c++) step();
    check("t2_count",   out_log.size() - base, 4);
    check("t2_credits", credits_o, 3'd0);
    check("t2_rdy1",    rdy_s[1], 1'b0);
    check("t2_busy",    busy_o, 1'b1);
    owed = 1;
    step(); check("t2_gap0", last_val, 1'b0);
    step(); check("t2_gap1", last_val, 1'b0);
    step(); check("t2_resume", last_val, 1'b1);
    check("t2_flit4", noc_data_out, mk(1, 4));
    check("t2_cred0", credits_o, 3'd0);

    // 3: round-robin across four sources offering single-flit packets
    do_reset(1);
    auto_yum = 1'b1;
    base     = out_log.size();
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < N; s++) push_pkt(s, 1, k);
    for (int c = 0; c < 12; c++) begin
      step();
      check("t3_stream", last_val, 1'b1);
    end
    for (int j = 0; j < 12; j++) check("t3_order", out_log[base + j], mk(j % 4, j / 4));

    // 4: wormhole lock on src2 with a two-cycle bubble while src0 and src3 wait
    base = out_log.size();
    push_pkt(2, 4, 10);
    step();
    push_pkt(0, 1, 20);
    push_pkt(3, 1, 30);
    step();
    hold[2] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("t4_rdy0_blocked", rdy_s[0], 1'b0);
      check("t4_rdy3_blocked", rdy_s[3], 1'b0);
      check("t4_rdy2_owner",   rdy_s[2], 1'b1);
      check("t4_busy",         busy_o,   1'b1);
    end
    hold[2] = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("t4_count", out_log.size() - base, 6);
    for (int k = 0; k < 4; k++) check("t4_src2", out_log[base + k], mk(2, 10 + k));
    check("t4_next_src3", out_log[base + 4], mk(3, 30));
    check("t4_then_src0", out_log[base + 5], mk(0, 20));

    // 5: spend and return a credit in the same cycle with one credit left
    do_reset(1);
    push_pkt(0, 6, 0);
    step();
    step();
    owed = 1;
    step(); check("t5_cred1", credits_o, 3'd1);
    step(); check("t5_cred_hold", credits_o, 3'd1); check("t5_val", last_val, 1'b1);
    step(); check("t5_b2b", last_val, 1'b1); check("t5_b2b_data", noc_data_out, mk(0, 4));
    check("t5_cred0", credits_o, 3'd0);

    // 6: reset in LOCKED with one credit
    owed = 1;
    step();
    step();
    check("t6_pre_cred", credits_o, 3'd1);
    check("t6_pre_busy", busy_o, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_cred", credits_o, 3'd4);
    check("t6_busy", busy_o, 1'b0);
    check("t6_val",  noc_val_out, 1'b0);
    clear_srcs();
    for (int s = 0; s < N; s++) push_pkt(s, 1, 40);
    step();
    check("t6_first_val",  last_val, 1'b1);
    check("t6_first_src0", noc_data_out, mk(0, 40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
